// File: rtl/sensor_monitor_pkg.sv
// Shared types and default constants for the delay-line timing sensor receiver.
package sensor_monitor_pkg;

    // FSM state encoding, 2 bits.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_REPORT  = 2'd2
    } state_t;

    localparam int   DEF_WIN_CYCLES = 1024;
    localparam logic DEF_EXPECT_LVL = 1'b1;

endpackage

// File: rtl/sensor_monitor_if.sv
// Valid/ready result channel between sensor_monitor (master) and the readout logic (slave).
interface sensor_monitor_if #(
    parameter int CNT_W = 11
);
    logic             meas_valid;
    logic             meas_ready;
    logic [CNT_W-1:0] meas_count;

    modport master (output meas_valid, output meas_count, input meas_ready);
    modport slave  (input meas_valid, input meas_count, output meas_ready);
endinterface

// File: rtl/sensor_monitor_capture.sv
// Capture flop pair for delayed_clk plus the event compare.
// Kept as its own module so the first capture flop can be preserved and
// placed right next to the delay line; delayed_clk is asynchronous to clk.
module sensor_capture
    import sensor_monitor_pkg::*;
#(
    parameter logic EXPECT_LVL = DEF_EXPECT_LVL
) (
    input  logic clk,
    input  logic rst_n,
    input  logic delayed_clk_i,
    output logic event_o
);

    logic cap_q;
    logic res_q;

    // Capture stage followed by a metastability-resolution stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_q <= EXPECT_LVL;
            res_q <= EXPECT_LVL;
        end else begin
            cap_q <= delayed_clk_i;
            res_q <= cap_q;
        end
    end

    assign event_o = (res_q != EXPECT_LVL);

endmodule

// File: rtl/sensor_monitor.sv
// Timing-sensor receiver: counts capture events over fixed windows, reports
// each window over a valid/ready channel and keeps a sticky threshold alarm.
// Optional feature macro: SENSOR_MONITOR_PEAK_EN adds a peak window-count register.
//
// state      | meaning
// -----------+------------------------------------------------------
// ST_IDLE    | waiting for enable; counters held
// ST_MEASURE | counting one sample per cycle toward WIN_CYCLES
// ST_REPORT  | result presented on meas_valid until accepted
module sensor_monitor
    import sensor_monitor_pkg::*;
#(
    parameter int   WIN_CYCLES = DEF_WIN_CYCLES,
    parameter int   CNT_W      = $clog2(WIN_CYCLES + 1),
    parameter logic EXPECT_LVL = DEF_EXPECT_LVL
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             delayed_clk,
    input  logic             enable,
    input  logic [CNT_W-1:0] threshold,
    sensor_monitor_if.master meas,
    output logic             alarm,
    input  logic             alarm_clr,
    output logic             busy,
    output logic [CNT_W-1:0] peak_count
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIN_CYCLES - 1);

    state_t           state_q;
    logic [CNT_W-1:0] win_cnt_q;
    logic [CNT_W-1:0] evt_cnt_q;
    logic             meas_valid_q;
    logic [CNT_W-1:0] meas_count_q;
    logic             alarm_q;
    logic             busy_q;

    logic             evt;
    logic [CNT_W-1:0] evt_sum_d;
    logic             win_done_d;
    logic             over_thr_d;

    sensor_capture #(
        .EXPECT_LVL (EXPECT_LVL)
    ) u_capture (
        .clk           (clk),
        .rst_n         (rst_n),
        .delayed_clk_i (delayed_clk),
        .event_o       (evt)
    );

    // Count including the current cycle's sample; the last sample of a window
    // never gets written back to evt_cnt_q, it goes straight to meas_count.
    assign evt_sum_d  = evt_cnt_q + CNT_W'(evt);
    assign win_done_d = (state_q == ST_MEASURE) && enable && (win_cnt_q == LAST_IDX);
    assign over_thr_d = (evt_sum_d > threshold);

    // Window FSM with counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            win_cnt_q    <= '0;
            evt_cnt_q    <= '0;
            meas_valid_q <= 1'b0;
            meas_count_q <= '0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (enable) begin
                        state_q   <= ST_MEASURE;
                        busy_q    <= 1'b1;
                        win_cnt_q <= '0;
                        evt_cnt_q <= '0;
                    end
                end
                ST_MEASURE: begin
                    if (!enable) begin
                        // Partial window is dropped; meas_count keeps the last result.
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else if (win_cnt_q == LAST_IDX) begin
                        state_q      <= ST_REPORT;
                        busy_q       <= 1'b0;
                        meas_valid_q <= 1'b1;
                        meas_count_q <= evt_sum_d;
                    end else begin
                        win_cnt_q <= win_cnt_q + CNT_W'(1);
                        evt_cnt_q <= evt_sum_d;
                    end
                end
                ST_REPORT: begin
                    if (meas.meas_ready) begin
                        meas_valid_q <= 1'b0;
                        if (enable) begin
                            state_q   <= ST_MEASURE;
                            busy_q    <= 1'b1;
                            win_cnt_q <= '0;
                            evt_cnt_q <= '0;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_q      <= ST_IDLE;
                    busy_q       <= 1'b0;
                    meas_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Sticky alarm; a completing over-threshold window beats a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alarm_q <= 1'b0;
        end else if (win_done_d && over_thr_d) begin
            alarm_q <= 1'b1;
        end else if (alarm_clr) begin
            alarm_q <= 1'b0;
        end
    end

`ifdef SENSOR_MONITOR_PEAK_EN
    logic [CNT_W-1:0] peak_q;

    // Running maximum of completed window counts; cleared together with the alarm.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            peak_q <= '0;
        end else if (win_done_d) begin
            if (evt_sum_d > peak_q) begin
                peak_q <= evt_sum_d;
            end
        end else if (alarm_clr) begin
            peak_q <= '0;
        end
    end

    assign peak_count = peak_q;
`else
    assign peak_count = '0;
`endif

    assign meas.meas_valid = meas_valid_q;
    assign meas.meas_count = meas_count_q;
    assign alarm           = alarm_q;
    assign busy            = busy_q;

endmodule
